rv32_regfile_ras: RTL and testbench

//  Parametrised integer register file with NUM_READ registered read ports and one write port.

---
 rtl/rv32_regfile_pkg.sv | 14 +
 rtl/rv32_regfile_ras_circ_stack.sv | 91 +++++++++
 rtl/rv32_regfile_ras.sv | 84 ++++++++
 tb/tb_rv32_regfile_ras.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_regfile_pkg.sv
// Shared defaults and helpers for the rv32 register file and its return-address stack.
package rv32_regfile_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_BITS_DEF   = 5;
  localparam int INSN_BYTES_DEF = 4;
  localparam int REG_ZERO       = 0;

  // Occupancy runs 0..2**ras_bits inclusive, so it needs one bit more than the pointer.
  function automatic int ras_cnt_width(input int ras_bits);
    return ras_bits + 1;
  endfunction

endpackage

// File: rtl/rv32_regfile_ras_circ_stack.sv
// Circular return-address stack: storage, top pointer, occupancy and sticky error flags.
module ras_circ_stack
  import rv32_regfile_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int RAS_BITS   = 4,
  parameter int INSN_BYTES = INSN_BYTES_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_i,
  input  logic            push_i,
  input  logic            pop_i,
  output logic [XLEN-1:0] ras_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_overflow_o,
  output logic            ras_underflow_o
);

  localparam int                DEPTH    = 2 ** RAS_BITS;
  localparam int                CW       = ras_cnt_width(RAS_BITS);
  localparam logic [RAS_BITS-1:0] TP_ONE  = RAS_BITS'(1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);

  logic [XLEN-1:0]     mem_q [DEPTH];
  logic [RAS_BITS-1:0] tp_q, tp_d, tp_dec, mem_waddr;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                empty, full, mem_we;
  logic [XLEN-1:0]     ret_addr;

  assign ret_addr = pc_i + XLEN'(INSN_BYTES);
  assign tp_dec   = tp_q - TP_ONE;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_FULL);

  // push and pop arrive as single-cycle strobes with no backpressure; both together
  // replace the top entry, except on an empty stack where it degenerates to a plain push.
  always_comb begin
    tp_d      = tp_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = tp_q;
    if (push_i && (!pop_i || empty)) begin
      mem_we = 1'b1;
      tp_d   = tp_q + TP_ONE;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CNT_ONE;
    end else if (push_i) begin
      mem_we    = 1'b1;
      mem_waddr = tp_dec;
    end else if (pop_i) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        tp_d  = tp_dec;
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is not cleared; an edge seen while reset is low must not write it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (rst_ni && mem_we) mem_q[mem_waddr] <= ret_addr;
  end

  assign ras_o           = empty ? '0 : mem_q[tp_dec];
  assign ras_empty_o     = empty;
  assign ras_full_o      = full;
  assign ras_overflow_o  = ovf_q;
  assign ras_underflow_o = unf_q;

endmodule

// File: rtl/rv32_regfile_ras.sv
// Integer register file (NUM_READ registered read ports, one write port) with integrated RAS.
// Optional REGFILE_BYPASS_EN forwards same-edge write data to matching read ports.
module rv32_regfile_ras
  import rv32_regfile_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_BITS   = REG_BITS_DEF,
  parameter int NUM_READ   = 2,
  parameter int RAS_BITS   = 4,
  parameter int INSN_BYTES = INSN_BYTES_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         write_i,
  input  logic [REG_BITS-1:0]          rd_addr_i,
  input  logic [XLEN-1:0]              data_i,
  input  logic                         read_i,
  input  logic [NUM_READ*REG_BITS-1:0] rs_addr_i,
  output logic [NUM_READ*XLEN-1:0]     rs_o,
  input  logic [XLEN-1:0]              pc_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  output logic [XLEN-1:0]              ras_o,
  output logic                         ras_empty_o,
  output logic                         ras_full_o,
  output logic                         ras_overflow_o,
  output logic                         ras_underflow_o
);

  localparam int                  NUM_REGS = 2 ** REG_BITS;
  localparam logic [REG_BITS-1:0] ZERO_A   = REG_BITS'(REG_ZERO);

  logic wr_en;
  assign wr_en = write_i && (rd_addr_i != ZERO_A);

  // One storage copy per read port, all written together, so each maps to a simple BRAM.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [XLEN-1:0]     bank_q [NUM_REGS];
    logic [REG_BITS-1:0] addr;
    logic [XLEN-1:0]     rd_d, rd_q;

    assign addr = rs_addr_i[k*REG_BITS +: REG_BITS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (rst_ni && wr_en) bank_q[rd_addr_i] <= data_i;
    end

    always_comb begin
      rd_d = rd_q;
      if (read_i) begin
        if (addr == ZERO_A) rd_d = '0;
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (rd_addr_i == addr)) rd_d = data_i;
`endif
        else rd_d = bank_q[addr];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_q <= '0;
      else         rd_q <= rd_d;
    end

    assign rs_o[k*XLEN +: XLEN] = rd_q;
  end

  ras_circ_stack #(
    .XLEN       (XLEN),
    .RAS_BITS   (RAS_BITS),
    .INSN_BYTES (INSN_BYTES)
  ) u_ras (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .pc_i            (pc_i),
    .push_i          (push_i),
    .pop_i           (pop_i),
    .ras_o           (ras_o),
    .ras_empty_o     (ras_empty_o),
    .ras_full_o      (ras_full_o),
    .ras_overflow_o  (ras_overflow_o),
    .ras_underflow_o (ras_underflow_o)
  );

endmodule

// File: tb/tb_rv32_regfile_ras.sv
// Bench for rv32_regfile_ras: directed scenarios plus randomized traffic against a queue/array model.
module tb_rv32_regfile_ras;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write, read, push, pop;
  logic [4:0]  wa, a0, a1;
  logic [31:0] wd, pc;
  logic [63:0] rs;
  logic [31:0] ras;
  logic        empty, full, ovf, unf;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  rv32_regfile_ras #(
    .XLEN(32), .REG_BITS(5), .NUM_READ(2), .RAS_BITS(2), .INSN_BYTES(4)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .write_i         (write),
    .rd_addr_i       (wa),
    .data_i          (wd),
    .read_i          (read),
    .rs_addr_i       ({a1, a0}),
    .rs_o            (rs),
    .pc_i            (pc),
    .push_i          (push),
    .pop_i           (pop),
    .ras_o           (ras),
    .ras_empty_o     (empty),
    .ras_full_o      (full),
    .ras_overflow_o  (ovf),
    .ras_underflow_o (unf)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_reg [32];
  bit          m_ok  [32];
  logic [31:0] m_rs  [2];
  bit          m_rs_ok [2];
  logic [31:0] m_ras_q [$];
  bit          m_ovf, m_unf;

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] a;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_rs[k]    = 32'h0;
        m_rs_ok[k] = 1'b1;
      end
      m_ras_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (read) begin
        for (int k = 0; k < 2; k++) begin
          a = (k == 0) ? a0 : a1;
          if (a == 5'd0) begin
            m_rs[k] = 32'h0; m_rs_ok[k] = 1'b1;
          end else begin
`ifdef REGFILE_BYPASS_EN
            if (write && wa == a) begin
              m_rs[k] = wd; m_rs_ok[k] = 1'b1;
            end else begin
              m_rs[k] = m_reg[a]; m_rs_ok[k] = m_ok[a];
            end
`else
            m_rs[k] = m_reg[a]; m_rs_ok[k] = m_ok[a];
`endif
          end
        end
      end
      if (write && wa != 5'd0) begin
        m_reg[wa] = wd;
        m_ok[wa]  = 1'b1;
      end
      if (push && pop && m_ras_q.size() > 0) begin
        m_ras_q[m_ras_q.size()-1] = pc + 32'd4;
      end else if (push) begin
        if (m_ras_q.size() == DEPTH) begin
          void'(m_ras_q.pop_front());
          m_ovf = 1'b1;
        end
        m_ras_q.push_back(pc + 32'd4);
      end else if (pop) begin
        if (m_ras_q.size() > 0) void'(m_ras_q.pop_back());
        else m_unf = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_rs_ok[0]) check("rs0", rs[31:0], m_rs[0]);
      if (m_rs_ok[1]) check("rs1", rs[63:32], m_rs[1]);
      check("ras", ras, (m_ras_q.size() > 0) ? m_ras_q[m_ras_q.size()-1] : 32'h0);
      check("empty", {31'd0, empty}, {31'd0, m_ras_q.size() == 0});
      check("full",  {31'd0, full},  {31'd0, m_ras_q.size() == DEPTH});
      check("ovf",   {31'd0, ovf},   {31'd0, m_ovf});
      check("unf",   {31'd0, unf},   {31'd0, m_unf});
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic w, input logic [4:0] w_a, input logic [31:0] w_d,
                       input logic r, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] p, input logic ps, input logic pp);
    write = w; wa = w_a; wd = w_d;
    read = r; a0 = r0; a1 = r1;
    pc = p; push = ps; pop = pp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    write = 1'b0; read = 1'b0; push = 1'b0; pop = 1'b0;
    wa = '0; a0 = '0; a1 = '0; wd = '0; pc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rs",    rs[31:0] | rs[63:32], 32'h0);
    check("reset_ras",   ras, 32'h0);
    check("reset_empty", {31'd0, empty}, 32'd1);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: write x5, read x5/x0
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0);
    check("t1_port0", rs[31:0], 32'hDEADBEEF);
    check("t1_port1", rs[63:32], 32'h0);

    // 2: writes to x0 are dropped
    cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    check("t2_port0", rs[31:0], 32'h0);
    check("t2_port1", rs[63:32], 32'h0);

    // 3: same-edge write/read of x7
    cycle(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd7, 32'h0, 1'b0, 1'b0);
`ifdef REGFILE_BYPASS_EN
    check("t3_same_edge", rs[31:0], 32'hA5A5A5A5);
`else
    check("t3_same_edge", rs[31:0], 32'h11);
`endif
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd5, 32'h0, 1'b0, 1'b0);
    check("t3_next_read", rs[31:0], 32'hA5A5A5A5);
    check("t3_port1_x5", rs[63:32], 32'hDEADBEEF);

    // 4: fill and overflow, then drain
    for (int i = 1; i <= 5; i++)
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h100 * i, 1'b1, 1'b0);
    check("t4_full", {31'd0, full}, 32'd1);
    check("t4_ovf",  {31'd0, ovf},  32'd1);
    check("t4_top",  ras, 32'h504);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("t4_pop1", ras, 32'h404);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("t4_pop2", ras, 32'h304);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("t4_pop3", ras, 32'h204);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("t4_pop4", ras, 32'h0);
    check("t4_empty", {31'd0, empty}, 32'd1);

    // 5: underflow, then push+pop on empty acts as push
    check("t5_unf_before", {31'd0, unf}, 32'd0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("t5_unf",   {31'd0, unf}, 32'd1);
    check("t5_ras",   ras, 32'h0);
    check("t5_empty", {31'd0, empty}, 32'd1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h80, 1'b1, 1'b1);
    check("t5_pp_top",   ras, 32'h84);
    check("t5_pp_empty", {31'd0, empty}, 32'd0);
    check("t5_pp_full",  {31'd0, full}, 32'd0);

    // 6: push+pop replaces the top; cnt unchanged
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h100, 1'b1, 1'b0);
    check("t6_push", ras, 32'h104);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h200, 1'b1, 1'b1);
    check("t6_pp_top", ras, 32'h204);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("t6_cnt1_empty", {31'd0, empty}, 32'd1);

    // reset asserted in the middle of a push cycle
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd7, 32'h0, 1'b0, 1'b0);
    push = 1'b1; pc = 32'h300; write = 1'b1; wa = 5'd5; wd = 32'h0BAD0BAD; read = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rs0",   rs[31:0], 32'h0);
    check("rst_rs1",   rs[63:32], 32'h0);
    check("rst_ras",   ras, 32'h0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full",  {31'd0, full}, 32'd0);
    check("rst_ovf",   {31'd0, ovf}, 32'd0);
    check("rst_unf",   {31'd0, unf}, 32'd0);
    write = 1'b0; read = 1'b0; push = 1'b0;
    rst_n = 1'b1;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 32'h0, 1'b0, 1'b0);
    check("rst_aborted_write", rs[31:0], 32'hDEADBEEF);

    // randomized traffic: fill the file first so every read has a defined value
    for (int r = 1; r < 32; r++)
      cycle(1'b1, 5'(r), $urandom, 1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            {$urandom_range(0, 32'hFFFF), 2'b00} << 2,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end
    idle();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
